// File: rtl/btn_event_arbiter_if.sv
// Event channel from the button arbiter to the display controller.
// valid/ready: once valid rises, idx holds stable until valid & ready at a rising edge.
interface btn_event_arbiter_if #(
    parameter int IDX_W = 2
);
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             ready;

    modport master (output valid, output idx, input ready);
    modport slave  (input valid, input idx, output ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// Round-robin serialiser of debounced button pulses onto one event channel, plus the shared
// debouncer sample tick. Optional auto-repeat on held buttons: define BTN_HOLD_REPEAT_EN.
module btn_event_arbiter #(
    parameter int NUM_BTN      = 4,
    parameter int IDX_W        = 2,
    parameter int TICK_DIV     = 10,
    parameter int REPEAT_TICKS = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTN-1:0]  btn_pulse,
    input  logic [NUM_BTN-1:0]  btn_level,
    output logic                sample_tick,
    btn_event_arbiter_if.master evt,
    output logic                evt_overflow,
    input  logic                ovf_clr,
    output logic                state_dbg
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   tick_cnt;
    logic [NUM_BTN-1:0] pending, pending_n, req, pulse_eff;
    logic [IDX_W-1:0]   last_grant, idx_q, pick;
    logic               found, grant, handshake, ovf_set;
    int                 cand;

    // Tick fires when the counter wraps, so the first strobe lands TICK_DIV cycles after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (tick_cnt == CNT_W'(TICK_DIV - 1));
            tick_cnt    <= (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
        end
    end

`ifdef BTN_HOLD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);

    logic [RPT_W-1:0]   rpt_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_req;

    always_comb begin
        rpt_req = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rpt_req[i] = btn_level[i] && !btn_pulse[i] && sample_tick &&
                         (rpt_cnt[i] == RPT_W'(REPEAT_TICKS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!rst_n)                         rpt_cnt[i] <= '0;
            else if (!btn_level[i] || btn_pulse[i]) rpt_cnt[i] <= '0;
            else if (rpt_req[i])                rpt_cnt[i] <= '0;
            else if (sample_tick)               rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
    end

    assign pulse_eff = btn_pulse | rpt_req;
`else
    logic level_unused;
    assign level_unused = ^btn_level;
    assign pulse_eff    = btn_pulse;
`endif

    assign req       = pending | pulse_eff;
    assign grant     = (state == IDLE) && found;
    assign handshake = (state == OFFER) && evt.ready;

    // Search starts just above the last granted index and wraps.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            cand = (int'(last_grant) + k) % NUM_BTN;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    // The granted bit absorbs its own same-cycle pulse; elsewhere a second press is a drop.
    always_comb begin
        pending_n = pending;
        ovf_set   = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (grant && (pick == IDX_W'(i))) begin
                pending_n[i] = 1'b0;
            end else if (pulse_eff[i]) begin
                if (pending[i]) ovf_set = 1'b1;
                else            pending_n[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            last_grant   <= IDX_W'(NUM_BTN - 1);
            idx_q        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pending <= pending_n;
            if (grant)     idx_q      <= pick;
            if (handshake) last_grant <= idx_q;
            if (ovf_set)      evt_overflow <= 1'b1;
            else if (ovf_clr) evt_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found)     state_n = OFFER;
            OFFER:   if (evt.ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // valid comes straight from state so an async reset drops it without a clock edge.
    always_comb begin
        evt.valid = (state == OFFER);
        evt.idx   = idx_q;
        state_dbg = state;
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: drivers push expected event indices into a queue,
// a monitor pops and compares on every handshake.
module tb_btn_event_arbiter;
  localparam int NUM_BTN = 4;
  localparam int IDX_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [NUM_BTN-1:0] btn_level;
  logic               sample_tick;
  logic               evt_overflow;
  logic               ovf_clr;
  logic               state_dbg;

  logic [IDX_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic hs_prev = 1'b0;

  btn_event_arbiter_if #(.IDX_W(IDX_W)) evt_if ();

  btn_event_arbiter #(
    .NUM_BTN(NUM_BTN), .IDX_W(IDX_W), .TICK_DIV(10), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse), .btn_level(btn_level),
    .sample_tick(sample_tick), .evt(evt_if.master), .evt_overflow(evt_overflow),
    .ovf_clr(ovf_clr), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // checking helpers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev <= 1'b0;
    end else begin
      if (evt_if.valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_evt got=%0d exp=none", evt_if.idx);
        end else begin
          if (evt_if.idx !== exp_q[0]) begin
            errors++;
            $display("FAIL evt_idx got=%0d exp=%0d", evt_if.idx, exp_q[0]);
          end
          if (evt_if.ready) void'(exp_q.pop_front());
        end
      end
      if (evt_if.valid && evt_if.ready) begin
        checks++;
        if (hs_prev) begin
          errors++;
          $display("FAIL evt_spacing got=back_to_back exp=gap");
        end
      end
      hs_prev <= evt_if.valid && evt_if.ready;
    end
  end

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_BTN-1:0] m);
    btn_pulse = m;
    step();
    btn_pulse = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0;
    btn_pulse = '0;
    btn_level = '0;
    ovf_clr = 1'b0;
    evt_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", evt_if.valid, 0);
    check("rst_idx", evt_if.idx, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_ovf", evt_overflow, 0);
    check("rst_state", state_dbg, 0);

    // 1: tick every 10 cycles, first in cycle 10
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("sample_tick", sample_tick, (k % 10 == 0) ? 1 : 0);
      if (k % 10 == 0) check("idle_valid", evt_if.valid, 0);
    end

    // 2: single pulse, one-cycle latency
    evt_if.ready = 1'b1;
    exp_q.push_back(2);
    pulse(4'b0100);
    check("latency_valid", evt_if.valid, 1);
    wait_drain(20);

    // 3: round-robin from fresh reset, then from last_grant=1
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    pulse(4'b1011);
    wait_drain(30);
    exp_q.push_back(1);
    pulse(4'b0010);
    wait_drain(20);
    exp_q.push_back(3); exp_q.push_back(0);
    pulse(4'b1001);
    wait_drain(20);

    // 4: stall with re-press of the offered button
    evt_if.ready = 1'b0;
    exp_q.push_back(1);
    pulse(4'b0010);
    step();
    pulse(4'b0010);
    repeat (3) step();
    check("stall_idx", evt_if.idx, 1);
    exp_q.push_back(1);
    evt_if.ready = 1'b1;
    wait_drain(20);
    check("offered_repress_ovf", evt_overflow, 0);

    // 5: overflow on double press, overflow beats clear
    do_reset();
    evt_if.ready = 1'b0;
    exp_q.push_back(0);
    pulse(4'b0001);
    pulse(4'b0100);
    check("ovf_first_press", evt_overflow, 0);
    btn_pulse = 4'b0100;
    ovf_clr = 1'b1;
    step();
    btn_pulse = '0;
    ovf_clr = 1'b0;
    check("ovf_wins_clr", evt_overflow, 1);
    exp_q.push_back(2);
    evt_if.ready = 1'b1;
    wait_drain(20);
    check("ovf_sticky", evt_overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", evt_overflow, 0);

    // 6: async reset mid-offer
    evt_if.ready = 1'b0;
    exp_q.push_back(2);
    pulse(4'b0100);
    pulse(4'b0010);
    pulse(4'b0010);
    check("pre_rst_ovf", evt_overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", evt_if.valid, 0);
    check("async_state", state_dbg, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_idx", evt_if.idx, 0);
    check("post_rst_ovf", evt_overflow, 0);
    check("post_rst_tick", sample_tick, 0);
    evt_if.ready = 1'b1;
    step();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    pulse(4'b1111);
    wait_drain(30);

`ifdef BTN_HOLD_REPEAT_EN
    exp_q.push_back(0); exp_q.push_back(0);
    btn_level = 4'b0001;
    wait_drain(200);
    btn_level = '0;
    repeat (40) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
